// File: rtl/vga_mem_arbiter.sv
// rtl/vga_mem_arbiter.sv - single-port VGA frame memory arbiter (scan > clear > game)
//
// Shares the frame memory's one read/write port between the scan-out reader
// (never stalled), an optional frame-clear engine and the game-logic requester.
// Port ownership is decided combinationally each cycle; a small owner tag
// remembers who issued the read so the memory's registered data (mem_q) is
// steered to the right valid/data pair one cycle later.
//
// Optional feature: define VGA_ARB_CLEAR_EN to build the clear engine and its
// ports (clear_start, clear_value, clear_busy, clear_done).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   scan_req/scan_addr       scan-out read strobe and address
//   scan_valid/scan_data     scan read response (data holds when valid low)
//   gm_req/gm_we/gm_addr/gm_wdata  game request, held until gm_ack
//   gm_ack                   game request granted this cycle
//   gm_rvalid/gm_rdata       game read response (data holds when valid low)
//   clear_start/clear_value  start a full-memory fill (clear builds only)
//   clear_busy/clear_done    sweep in progress / pulse after last write
//   mem_addr/mem_wdata/mem_we  memory port drive
//   mem_q                    memory registered read data

module vga_mem_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scan_req,
    input  logic [ADDR_WIDTH-1:0] scan_addr,
    output logic                  scan_valid,
    output logic [DATA_WIDTH-1:0] scan_data,
    input  logic                  gm_req,
    input  logic                  gm_we,
    input  logic [ADDR_WIDTH-1:0] gm_addr,
    input  logic [DATA_WIDTH-1:0] gm_wdata,
    output logic                  gm_ack,
    output logic                  gm_rvalid,
    output logic [DATA_WIDTH-1:0] gm_rdata,
`ifdef VGA_ARB_CLEAR_EN
    input  logic                  clear_start,
    input  logic [DATA_WIDTH-1:0] clear_value,
    output logic                  clear_busy,
    output logic                  clear_done,
`endif
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    // Who issued the read that mem_q will answer next cycle.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_SCAN = 2'd1,
        TAG_GAME = 2'd2
    } tag_e;

    tag_e                  tag_q, tag_d;
    logic [DATA_WIDTH-1:0] scan_hold_q, scan_hold_d;
    logic [DATA_WIDTH-1:0] gm_hold_q, gm_hold_d;

    logic sweep_active;
    logic scan_grant;
    logic game_grant;

`ifdef VGA_ARB_CLEAR_EN
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } clr_state_e;

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;
    logic                  done_q, done_d;
    logic                  clear_grant;

    assign sweep_active = (state_q == ST_SWEEP);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    fill_d  = clear_value;
                    cnt_d   = '0;
                    state_d = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                // A scan cycle steals the port, so the counter simply waits.
                if (!scan_req) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fill_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            done_q  <= done_d;
        end
    end

    assign clear_grant = !rst && sweep_active && !scan_req;
    assign clear_busy  = sweep_active;
    assign clear_done  = done_q;
`else
    assign sweep_active = 1'b0;
`endif

    // The game is locked out for the whole sweep, even on scan cycles, so a
    // sweep always finishes in one pass.
    assign scan_grant = !rst && scan_req;
    assign game_grant = !rst && gm_req && !scan_req && !sweep_active;
    assign gm_ack     = game_grant;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (scan_grant) begin
            mem_addr = scan_addr;
        end
`ifdef VGA_ARB_CLEAR_EN
        else if (clear_grant) begin
            mem_addr  = cnt_q;
            mem_wdata = fill_q;
            mem_we    = 1'b1;
        end
`endif
        else if (game_grant) begin
            mem_addr  = gm_addr;
            mem_wdata = gm_wdata;
            mem_we    = gm_we;
        end
    end

    always_comb begin
        tag_d = TAG_NONE;
        if (scan_grant) begin
            tag_d = TAG_SCAN;
        end else if (game_grant && !gm_we) begin
            tag_d = TAG_GAME;
        end
    end

    // Hold registers capture mem_q on the response cycle so the data outputs
    // keep their last value once valid drops.
    assign scan_hold_d = (tag_q == TAG_SCAN) ? mem_q : scan_hold_q;
    assign gm_hold_d   = (tag_q == TAG_GAME) ? mem_q : gm_hold_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q       <= TAG_NONE;
            scan_hold_q <= '0;
            gm_hold_q   <= '0;
        end else begin
            tag_q       <= tag_d;
            scan_hold_q <= scan_hold_d;
            gm_hold_q   <= gm_hold_d;
        end
    end

    assign scan_valid = (tag_q == TAG_SCAN);
    assign gm_rvalid  = (tag_q == TAG_GAME);
    assign scan_data  = scan_valid ? mem_q : scan_hold_q;
    assign gm_rdata   = gm_rvalid ? mem_q : gm_hold_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb/tb_vga_mem_arbiter.sv - scoreboard bench for vga_mem_arbiter with memory and reference model

module tb_vga_mem_arbiter;

    localparam int DW    = 8;
    localparam int AW    = 13;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          scan_req;
    logic [AW-1:0] scan_addr;
    logic          scan_valid;
    logic [DW-1:0] scan_data;
    logic          gm_req;
    logic          gm_we;
    logic [AW-1:0] gm_addr;
    logic [DW-1:0] gm_wdata;
    logic          gm_ack;
    logic          gm_rvalid;
    logic [DW-1:0] gm_rdata;
`ifdef VGA_ARB_CLEAR_EN
    logic          clear_start;
    logic [DW-1:0] clear_value;
    logic          clear_busy;
    logic          clear_done;
`endif
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_q;

    always #5 clk = ~clk;

    vga_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .scan_req    (scan_req),
        .scan_addr   (scan_addr),
        .scan_valid  (scan_valid),
        .scan_data   (scan_data),
        .gm_req      (gm_req),
        .gm_we       (gm_we),
        .gm_addr     (gm_addr),
        .gm_wdata    (gm_wdata),
        .gm_ack      (gm_ack),
        .gm_rvalid   (gm_rvalid),
        .gm_rdata    (gm_rdata),
`ifdef VGA_ARB_CLEAR_EN
        .clear_start (clear_start),
        .clear_value (clear_value),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
`endif
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_q       (mem_q)
    );

    // Frame memory: single port, registered read data.
    logic [DW-1:0] mem_arr [DEPTH];
    logic          mem_init;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem_arr[i] <= DW'((i * 37) ^ 8'h5A);
        end else begin
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
            mem_q <= mem_arr[mem_addr];
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    logic [39:0]   scan_sb[$];
    logic [39:0]   gm_sb[$];
    bit            clr_sweep;
    int            clr_next;
    logic [DW-1:0] clr_val;
    bit            done_exp;
    bit            last_ack;
    logic [DW-1:0] scan_last;
    logic [DW-1:0] gm_last;
    bit            mon_en;
    int unsigned   cyc;
    int            checks;
    int            failures;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Response monitor: pops the scoreboard whenever a valid fires.
    always @(negedge clk) begin
        logic [39:0] e;
        if (mon_en) begin
            if (scan_valid === 1'b1) begin
                if (scan_sb.size() == 0) begin
                    check("scan_spurious_valid", 1, 0);
                end else begin
                    e = scan_sb.pop_front();
                    check("scan_latency", 64'(cyc), 64'(e[39:8]));
                    check("scan_data", scan_data, e[7:0]);
                    scan_last = e[7:0];
                end
            end else if (!rst) begin
                check("scan_data_hold", scan_data, scan_last);
            end
            if (gm_rvalid === 1'b1) begin
                if (gm_sb.size() == 0) begin
                    check("gm_spurious_rvalid", 1, 0);
                end else begin
                    e = gm_sb.pop_front();
                    check("gm_latency", 64'(cyc), 64'(e[39:8]));
                    check("gm_rdata", gm_rdata, e[7:0]);
                    gm_last = e[7:0];
                end
            end else if (!rst) begin
                check("gm_rdata_hold", gm_rdata, gm_last);
            end
        end
    end

    // Evaluate one cycle of the rules: who owns the port, what the memory
    // port must show, and what each read must later return.
    task automatic eval_cycle();
        bit            own_scan, own_clr, exp_ack, exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wd;
        bit            start;
        own_scan = !rst && scan_req;
        own_clr  = !rst && clr_sweep && !scan_req;
        exp_ack  = !rst && gm_req && !scan_req && !clr_sweep;
        start    = 1'b0;
`ifdef VGA_ARB_CLEAR_EN
        start = clear_start;
        check("clear_busy", clear_busy, clr_sweep);
        check("clear_done", clear_done, done_exp);
`endif
        check("gm_ack", gm_ack, exp_ack);
        exp_we = 1'b0; exp_addr = '0; exp_wd = '0;
        if (own_scan) begin
            exp_addr = scan_addr;
        end else if (own_clr) begin
            exp_we = 1'b1; exp_addr = clr_next[AW-1:0]; exp_wd = clr_val;
        end else if (exp_ack) begin
            exp_we = gm_we; exp_addr = gm_addr; exp_wd = gm_wdata;
        end
        check("mem_we", mem_we, exp_we);
        check("mem_addr", mem_addr, exp_addr);
        if (!own_scan) check("mem_wdata", mem_wdata, exp_wd);

        if (own_scan) scan_sb.push_back({cyc + 32'd1, ref_mem[scan_addr]});
        if (exp_ack) begin
            if (gm_we) ref_mem[gm_addr] = gm_wdata;
            else gm_sb.push_back({cyc + 32'd1, ref_mem[gm_addr]});
        end
        last_ack = exp_ack;
        done_exp = 1'b0;
        if (rst) begin
            clr_sweep = 1'b0;
            scan_last = '0;
            gm_last   = '0;
        end else if (clr_sweep) begin
            if (own_clr) begin
                ref_mem[clr_next] = clr_val;
                if (clr_next == DEPTH - 1) begin
                    clr_sweep = 1'b0;
                    done_exp  = 1'b1;
                end
                clr_next++;
            end
        end else if (start) begin
`ifdef VGA_ARB_CLEAR_EN
            clr_val = clear_value;
`endif
            clr_sweep = 1'b1;
            clr_next  = 0;
        end
    endtask

    // Inputs are applied 1 time unit after the rising edge; checks at the falling edge.
    task automatic tick();
        @(negedge clk);
        eval_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy, scans;
        bit acked;
        checks = 0; failures = 0; cyc = 0;
        mon_en = 0; clr_sweep = 0; clr_next = 0; clr_val = '0; done_exp = 0;
        last_ack = 0; scan_last = '0; gm_last = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'((i * 37) ^ 8'h5A);
        rst = 1; mem_init = 1;
        scan_req = 0; scan_addr = '0; gm_req = 0; gm_we = 0; gm_addr = '0; gm_wdata = '0;
`ifdef VGA_ARB_CLEAR_EN
        clear_start = 0; clear_value = '0;
`endif
        @(posedge clk); #1;
        mem_init = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

        // Reset / idle state
        @(negedge clk);
        check("rst_scan_valid", scan_valid, 0);
        check("rst_scan_data", scan_data, 0);
        check("rst_gm_rvalid", gm_rvalid, 0);
        check("rst_gm_rdata", gm_rdata, 0);
        check("rst_gm_ack", gm_ack, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
`ifdef VGA_ARB_CLEAR_EN
        check("rst_clear_busy", clear_busy, 0);
        check("rst_clear_done", clear_done, 0);
`endif
        @(posedge clk); #1;
        mon_en = 1;

        // Game write then read of the same address
        gm_req = 1; gm_we = 1; gm_addr = 13'h0100; gm_wdata = 8'hA5; tick();
        gm_we = 0; gm_wdata = 8'h00; tick();
        gm_req = 0; tick(); tick();

        // Simultaneous scan and game: scan first, game the next cycle
        scan_req = 1; scan_addr = 13'h0200; gm_req = 1; gm_we = 0; gm_addr = 13'h0100; tick();
        scan_req = 0; tick();
        gm_req = 0; tick(); tick();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            scan_req  = ($urandom_range(0, 2) == 0);
            scan_addr = AW'($urandom_range(0, 31));
            if (!gm_req || last_ack) begin
                gm_req   = ($urandom_range(0, 3) != 0);
                gm_we    = $urandom_range(0, 1) == 1;
                gm_addr  = AW'($urandom_range(0, 31));
                gm_wdata = DW'($urandom);
            end
            tick();
        end
        scan_req = 0; gm_req = 0; tick(); tick();

`ifdef VGA_ARB_CLEAR_EN
        // Clear with a pending game read; ack only after the sweep
        clear_start = 1; clear_value = 8'h3C; tick();
        clear_start = 0; gm_req = 1; gm_we = 0; gm_addr = 13'h1FFF;
        busy = 0; acked = 0;
        for (int i = 0; i < 9000 && !acked; i++) begin
            if (clear_busy === 1'b1) busy++;
            tick();
            if (last_ack) acked = 1;
        end
        gm_req = 0;
        check("clear_gm_acked", acked, 1);
        check("clear_busy_cycles", busy, DEPTH);
        gm_req = 1; gm_addr = 13'h0000; tick();
        gm_addr = 13'h1000; tick();
        gm_req = 0; tick(); tick();

        // Clear with scan every 4th cycle
        clear_start = 1; clear_value = DW'($urandom); tick();
        clear_start = 0; busy = 0; scans = 0;
        for (int i = 0; i < 12000; i++) begin
            scan_req  = (i % 4 == 3);
            scan_addr = AW'($urandom);
            if (clear_busy !== 1'b1) break;
            busy++;
            if (scan_req) scans++;
            tick();
        end
        scan_req = 0;
        check("clear_scan_cycles", busy, DEPTH + scans);
        tick(); tick();

        // Reset mid-sweep at address 0x0800, then restart from 0
        clear_start = 1; clear_value = 8'hC3; tick();
        clear_start = 0;
        for (int i = 0; i < 3000 && clr_next != 12'h800; i++) tick();
        check("abort_point", clr_next, 32'h800);
        rst = 1; tick();
        rst = 0;
        check("abort_busy_low", clear_busy, 0);
        for (int i = 0; i < 20; i++) tick();
        clear_start = 1; clear_value = 8'h96; tick();
        clear_start = 0;
        for (int i = 0; i < 12000 && clr_sweep; i++) begin
            scan_req  = ($urandom_range(0, 5) == 0);
            scan_addr = AW'($urandom);
            tick();
        end
        scan_req = 0;
        check("restart_finished", clr_sweep, 0);
        tick();
        gm_req = 1; gm_we = 0; gm_addr = 13'h0000; tick();
        gm_addr = 13'h0800; tick();
        gm_addr = 13'h1FFF; tick();
        gm_req = 0; tick(); tick();
`endif

        tick(); tick();
        check("scan_sb_empty", scan_sb.size(), 0);
        check("gm_sb_empty", gm_sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
